// File: rtl/acc_seq_pkg.sv
// acc_seq_pkg: shared types and constants for the accelerator job sequencer.
//   state_t       - sequencer FSM states (WRITE_ABORT only with ACC_ABORT_EN)
//   ST_*          - bit positions inside the ACB status/command word
//   STATUS_*      - status words written back to the ACB
//   is_job_state  - states in which a running job may be aborted
// Optional feature macro: ACC_ABORT_EN
package acc_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WRITE_BUSY,
    S_RESET_H,
    S_READ_BLK,
    S_UPD1,
    S_HASH,
    S_UPD2,
    S_NEXT,
    S_DBL_INIT,
    S_WRITE_H,
    S_WRITE_DONE
`ifdef ACC_ABORT_EN
    , S_WRITE_ABORT
`endif
  } state_t;

  localparam int ST_VALID     = 0;
  localparam int ST_DONE      = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_ABORT_REQ = 3;
  localparam int ST_ABORTED   = 4;
  localparam int ST_DBL       = 5;

  localparam logic [31:0] STATUS_BUSY    = (32'h1 << ST_VALID) | (32'h1 << ST_BUSY);
  localparam logic [31:0] STATUS_DONE    = (32'h1 << ST_DONE);
  localparam logic [31:0] STATUS_ABORTED = (32'h1 << ST_DONE) | (32'h1 << ST_ABORTED);

  // RESET_H .. DBL_INIT: the hashing part of a job, after the busy write
  // has landed and before the digest write-back has started.
  function automatic logic is_job_state(state_t s);
    case (s)
      S_RESET_H, S_READ_BLK, S_UPD1, S_HASH,
      S_UPD2, S_NEXT, S_DBL_INIT: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/acc_job_sequencer_if.sv
// acc_job_sequencer_if: memory-side bus of the job sequencer.
//   mem_listen_*   - snooped CPU writes (command word at the ACB)
//   mem_acc_read_* - block read request, read_data_valid is the arbiter grant
//   mem_acc_write_*- write request, write_done is the arbiter completion
// Modports: master = sequencer, slave = memory/arbiter side.
interface acc_job_sequencer_if #(
  parameter int MEM_LISTEN_ADDR_SIZE    = 16,
  parameter int MEM_LISTEN_DATA_SIZE    = 32,
  parameter int MEM_ACC_READ_ADDR_SIZE  = 16,
  parameter int MEM_ACC_READ_DATA_SIZE  = 512,
  parameter int MEM_ACC_WRITE_ADDR_SIZE = 16,
  parameter int MEM_ACC_WRITE_DATA_SIZE = 32
);
  logic                               mem_listen_en;
  logic [MEM_LISTEN_ADDR_SIZE-1:0]    mem_listen_addr;
  logic [MEM_LISTEN_DATA_SIZE-1:0]    mem_listen_data;
  logic                               mem_acc_read_en;
  logic [MEM_ACC_READ_ADDR_SIZE-1:0]  mem_acc_read_addr;
  logic [MEM_ACC_READ_DATA_SIZE-1:0]  mem_acc_read_data;
  logic                               mem_acc_read_data_valid;
  logic                               mem_acc_write_en;
  logic [MEM_ACC_WRITE_ADDR_SIZE-1:0] mem_acc_write_addr;
  logic [MEM_ACC_WRITE_DATA_SIZE-1:0] mem_acc_write_data;
  logic                               mem_acc_write_done;

  modport master (
    input  mem_listen_en, mem_listen_addr, mem_listen_data,
    output mem_acc_read_en, mem_acc_read_addr,
    input  mem_acc_read_data, mem_acc_read_data_valid,
    output mem_acc_write_en, mem_acc_write_addr, mem_acc_write_data,
    input  mem_acc_write_done
  );

  modport slave (
    output mem_listen_en, mem_listen_addr, mem_listen_data,
    input  mem_acc_read_en, mem_acc_read_addr,
    output mem_acc_read_data, mem_acc_read_data_valid,
    input  mem_acc_write_en, mem_acc_write_addr, mem_acc_write_data,
    output mem_acc_write_done
  );
endinterface

// File: rtl/acc_step_counter.sv
// acc_step_counter: up-counter with synchronous clear and increment enable.
//   clk, rst_n - clock, synchronous active-low reset
//   clr        - clear to zero (wins over inc)
//   inc        - advance by one
//   cnt        - current value
module acc_step_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + WIDTH'(1);
  end
endmodule

// File: rtl/acc_job_sequencer.sv
// acc_job_sequencer: control FSM for a chained multi-block hashing job.
//   clk, rst_n        - clock, synchronous active-low reset
//   bus (master)      - CPU listen port, block read port, status/digest write port
//   cm_out            - 256-bit digest from the compressor
//   ms_init/ms_enable - message scheduler control
//   cm_*              - compressor control and current round
//   msg_sel           - pass index (block number, NUM_BLOCKS for the 2nd hash)
//   should_save_hash  - latch intermediate digest
//   hash_done         - one-cycle pulse when the final status write completes
// Optional feature macro: ACC_ABORT_EN (CPU abort with data[3], status 0x12).
module acc_job_sequencer
  import acc_seq_pkg::*;
#(
  parameter int          MEM_LISTEN_ADDR_SIZE    = 16,
  parameter int          MEM_LISTEN_DATA_SIZE    = 32,
  parameter int          MEM_ACC_READ_ADDR_SIZE  = 16,
  parameter int          MEM_ACC_READ_DATA_SIZE  = 512,
  parameter int          MEM_ACC_WRITE_ADDR_SIZE = 16,
  parameter int          MEM_ACC_WRITE_DATA_SIZE = 32,
  parameter logic [15:0] HCB_MSG_ADDR            = 16'h1008,
  parameter logic [15:0] READ_STRIDE             = 16'h0040,
  parameter logic [15:0] ACB_START_ADDR          = 16'h5000,
  parameter logic [15:0] ACB_H0_ADDR             = 16'h5008,
  parameter logic [15:0] WRITE_ADDR_STRIDE       = 16'h0004,
  parameter int          NUM_BLOCKS              = 2,
  parameter int          HASH_CYCLE_COUNT        = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  acc_job_sequencer_if.master               bus,
  input  logic [255:0]                      cm_out,
  output logic                              ms_init,
  output logic                              ms_enable,
  output logic                              cm_is_hashing,
  output logic                              cm_update_A_H,
  output logic                              cm_update_H0_7,
  output logic                              cm_rst_hash_n,
  output logic [$clog2(HASH_CYCLE_COUNT):0] cm_cycle_count,
  output logic [2:0]                        msg_sel,
  output logic                              should_save_hash,
  output logic                              hash_done
);

  localparam int CW    = $clog2(HASH_CYCLE_COUNT) + 1;
  localparam int WD    = MEM_ACC_WRITE_DATA_SIZE;
  localparam int WORDS = 256 / WD;
  localparam int WIW   = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef logic [MEM_LISTEN_ADDR_SIZE-1:0]    laddr_t;
  typedef logic [MEM_ACC_READ_ADDR_SIZE-1:0]  raddr_t;
  typedef logic [MEM_ACC_WRITE_ADDR_SIZE-1:0] waddr_t;
  typedef logic [WD-1:0]                      wdata_t;

  localparam logic [CW-1:0]  RND_END  = CW'(HASH_CYCLE_COUNT);
  localparam logic [2:0]     LAST_BLK = 3'(NUM_BLOCKS - 1);
  localparam logic [WIW-1:0] LAST_WRD = WIW'(WORDS - 1);

  state_t state, nxt;
  logic   dbl_mode;

  logic [CW-1:0]  rnd;
  logic [2:0]     blk;
  logic [WIW-1:0] wrd;
  logic rnd_inc, rnd_clr, blk_inc, blk_clr, wrd_inc, wrd_clr;

  logic [WORDS-1:0][WD-1:0] digest_words;
  assign digest_words = cm_out;

  // Command word decode; only acted on in the states that allow it.
  logic cmd_hit, start_hit;
  assign cmd_hit   = bus.mem_listen_en && (bus.mem_listen_addr == laddr_t'(ACB_START_ADDR));
  assign start_hit = cmd_hit && bus.mem_listen_data[ST_VALID];
`ifdef ACC_ABORT_EN
  logic abort_hit;
  assign abort_hit = cmd_hit && bus.mem_listen_data[ST_ABORT_REQ] && is_job_state(state);
`endif

  acc_step_counter #(.WIDTH(CW)) u_rnd_cnt (
    .clk(clk), .rst_n(rst_n), .clr(rnd_clr), .inc(rnd_inc), .cnt(rnd)
  );
  acc_step_counter #(.WIDTH(3)) u_blk_cnt (
    .clk(clk), .rst_n(rst_n), .clr(blk_clr), .inc(blk_inc), .cnt(blk)
  );
  acc_step_counter #(.WIDTH(WIW)) u_wrd_cnt (
    .clk(clk), .rst_n(rst_n), .clr(wrd_clr), .inc(wrd_inc), .cnt(wrd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      dbl_mode <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && start_hit) dbl_mode <= bus.mem_listen_data[ST_DBL];
    end
  end

  assign cm_cycle_count = rnd;
  assign msg_sel        = blk;

  always_comb begin
    nxt                    = state;
    bus.mem_acc_read_en    = 1'b0;
    bus.mem_acc_read_addr  = '0;
    bus.mem_acc_write_en   = 1'b0;
    bus.mem_acc_write_addr = '0;
    bus.mem_acc_write_data = '0;
    ms_init                = 1'b0;
    ms_enable              = 1'b0;
    cm_is_hashing          = 1'b0;
    cm_update_A_H          = 1'b0;
    cm_update_H0_7         = 1'b0;
    cm_rst_hash_n          = 1'b1;
    should_save_hash       = 1'b0;
    hash_done              = 1'b0;
    rnd_inc = 1'b0; rnd_clr = 1'b0;
    blk_inc = 1'b0; blk_clr = 1'b0;
    wrd_inc = 1'b0; wrd_clr = 1'b0;

    case (state)
      S_IDLE: begin
        rnd_clr = 1'b1; blk_clr = 1'b1; wrd_clr = 1'b1;
        if (start_hit) nxt = S_WRITE_BUSY;
      end
      S_WRITE_BUSY: begin
        bus.mem_acc_write_en   = 1'b1;
        bus.mem_acc_write_addr = waddr_t'(ACB_START_ADDR);
        bus.mem_acc_write_data = wdata_t'(STATUS_BUSY);
        if (bus.mem_acc_write_done) nxt = S_RESET_H;
      end
      S_RESET_H: begin
        cm_rst_hash_n = 1'b0;
        nxt           = S_READ_BLK;
      end
      S_READ_BLK: begin
        bus.mem_acc_read_en   = 1'b1;
        bus.mem_acc_read_addr = raddr_t'(HCB_MSG_ADDR) + raddr_t'(blk) * raddr_t'(READ_STRIDE);
        if (bus.mem_acc_read_data_valid) nxt = S_UPD1;
      end
      S_UPD1: begin
        cm_update_A_H = 1'b1;
        ms_init       = 1'b1;
        nxt           = S_HASH;
      end
      S_HASH: begin
        // Rounds 0..N-1 run with enables; the count==N cycle is a quiet
        // turnaround, giving 66 cycles UPD1->UPD2 for N=64.
        if (rnd == RND_END) begin
          rnd_clr = 1'b1;
          nxt     = S_UPD2;
        end else begin
          cm_is_hashing = 1'b1;
          ms_enable     = 1'b1;
          rnd_inc       = 1'b1;
        end
      end
      S_UPD2: begin
        cm_update_H0_7 = 1'b1;
        nxt            = S_NEXT;
      end
      S_NEXT: begin
        should_save_hash = 1'b1;
        if (blk < LAST_BLK) begin
          blk_inc = 1'b1;
          nxt     = S_READ_BLK;
        end else if (dbl_mode && blk == LAST_BLK) begin
          // blk == NUM_BLOCKS marks the double-hash pass and also
          // records that it has been done.
          blk_inc = 1'b1;
          nxt     = S_DBL_INIT;
        end else begin
          blk_clr = 1'b1;
          nxt     = S_WRITE_H;
        end
      end
      S_DBL_INIT: begin
        cm_rst_hash_n = 1'b0;
        nxt           = S_UPD1;
      end
      S_WRITE_H: begin
        bus.mem_acc_write_en   = 1'b1;
        bus.mem_acc_write_addr = waddr_t'(ACB_H0_ADDR) + waddr_t'(wrd) * waddr_t'(WRITE_ADDR_STRIDE);
        bus.mem_acc_write_data = digest_words[wrd];
        if (bus.mem_acc_write_done) begin
          if (wrd == LAST_WRD) begin
            wrd_clr = 1'b1;
            nxt     = S_WRITE_DONE;
          end else begin
            wrd_inc = 1'b1;
          end
        end
      end
      S_WRITE_DONE: begin
        bus.mem_acc_write_en   = 1'b1;
        bus.mem_acc_write_addr = waddr_t'(ACB_START_ADDR);
        bus.mem_acc_write_data = wdata_t'(STATUS_DONE);
        if (bus.mem_acc_write_done) begin
          hash_done = 1'b1;
          nxt       = S_IDLE;
        end
      end
`ifdef ACC_ABORT_EN
      S_WRITE_ABORT: begin
        rnd_clr = 1'b1; blk_clr = 1'b1; wrd_clr = 1'b1;
        bus.mem_acc_write_en   = 1'b1;
        bus.mem_acc_write_addr = waddr_t'(ACB_START_ADDR);
        bus.mem_acc_write_data = wdata_t'(STATUS_ABORTED);
        if (bus.mem_acc_write_done) nxt = S_IDLE;
      end
`endif
      default: nxt = S_IDLE;
    endcase

`ifdef ACC_ABORT_EN
    // Abort overrides whatever transition the state computed this cycle;
    // counters are cleared now so the abort state shows round 0.
    if (abort_hit) begin
      nxt     = S_WRITE_ABORT;
      rnd_inc = 1'b0; blk_inc = 1'b0;
      rnd_clr = 1'b1; blk_clr = 1'b1; wrd_clr = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_acc_job_sequencer.sv
module tb_acc_job_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  acc_job_sequencer_if #(.MEM_ACC_WRITE_DATA_SIZE(32)) bus ();
  acc_job_sequencer_if #(.MEM_ACC_WRITE_DATA_SIZE(64)) bus64 ();

  logic [255:0] cm = '0;
  logic ms_init, ms_enable, cm_is_hashing, cm_update_A_H, cm_update_H0_7, cm_rst_hash_n;
  logic [6:0] cyc;
  logic [2:0] msg_sel;
  logic save, hash_done;
  logic ms_init_b, ms_enable_b, hashing_b, upd_ah_b, upd_h0_b, rst_hash_n_b, save_b, hash_done_b;
  logic [6:0] cyc_b;
  logic [2:0] msg_sel_b;

  acc_job_sequencer dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .cm_out(cm),
    .ms_init(ms_init), .ms_enable(ms_enable), .cm_is_hashing(cm_is_hashing),
    .cm_update_A_H(cm_update_A_H), .cm_update_H0_7(cm_update_H0_7),
    .cm_rst_hash_n(cm_rst_hash_n), .cm_cycle_count(cyc), .msg_sel(msg_sel),
    .should_save_hash(save), .hash_done(hash_done)
  );

  acc_job_sequencer #(.MEM_ACC_WRITE_DATA_SIZE(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .bus(bus64), .cm_out(cm),
    .ms_init(ms_init_b), .ms_enable(ms_enable_b), .cm_is_hashing(hashing_b),
    .cm_update_A_H(upd_ah_b), .cm_update_H0_7(upd_h0_b),
    .cm_rst_hash_n(rst_hash_n_b), .cm_cycle_count(cyc_b), .msg_sel(msg_sel_b),
    .should_save_hash(save_b), .hash_done(hash_done_b)
  );

  // Arbiter model: grants after a per-request delay (0 when arb_max==0).
  // spur forces done/valid high to check that unrequested grants are ignored.
  int   arb_max = 0;
  int   wcnt = 0, rcnt = 0, wdly = 0, rdly = 0;
  logic spur = 1'b0;
  assign bus.mem_acc_write_done      = (bus.mem_acc_write_en && wcnt >= wdly) || spur;
  assign bus.mem_acc_read_data_valid = (bus.mem_acc_read_en && rcnt >= rdly) || spur;
  assign bus.mem_acc_read_data       = '0;
  always @(posedge clk) begin
    if (bus.mem_acc_write_en && !bus.mem_acc_write_done) wcnt <= wcnt + 1;
    else begin
      wcnt <= 0;
      wdly <= (arb_max == 0) ? 0 : int'($urandom_range(unsigned'(arb_max), 1));
    end
    if (bus.mem_acc_read_en && !bus.mem_acc_read_data_valid) rcnt <= rcnt + 1;
    else begin
      rcnt <= 0;
      rdly <= (arb_max == 0) ? 0 : int'($urandom_range(unsigned'(arb_max), 1));
    end
  end
  assign bus64.mem_acc_write_done      = bus64.mem_acc_write_en;
  assign bus64.mem_acc_read_data_valid = bus64.mem_acc_read_en;
  assign bus64.mem_acc_read_data       = '0;

  // Scoreboard queues and observation counters
  logic [47:0] exp_w[$], obs_w[$];
  logic [15:0] exp_r[$], obs_r[$];
  logic [2:0]  exp_sel[$], obs_sel[$];
  logic [79:0] obs64[$];
  int hd_cnt, en_cnt, rst_cnt, save_cnt, stab_err;
  logic pend_w = 1'b0, pend_r = 1'b0;
  logic [47:0] pw;
  logic [15:0] pr;
  int n_assert = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] outs();
    return {12'h0, bus.mem_acc_read_en, bus.mem_acc_write_en, ms_init, ms_enable, cm_is_hashing,
            cm_update_A_H, cm_update_H0_7, cm_rst_hash_n, save, hash_done, cyc, msg_sel,
            bus.mem_acc_write_addr, bus.mem_acc_write_data, bus.mem_acc_read_addr};
  endfunction
  localparam logic [95:0] IDLE_OUTS = {12'h0, 10'b0000000100, 7'd0, 3'd0, 16'h0, 32'h0, 16'h0};

  // One cycle: wait for the falling edge and record what the DUTs present.
  task automatic tick();
    @(negedge clk);
    if (pend_w && !(bus.mem_acc_write_en && {bus.mem_acc_write_addr, bus.mem_acc_write_data} == pw))
      stab_err++;
    if (pend_r && !(bus.mem_acc_read_en && bus.mem_acc_read_addr == pr)) stab_err++;
    pend_w = bus.mem_acc_write_en && !bus.mem_acc_write_done;
    pw     = {bus.mem_acc_write_addr, bus.mem_acc_write_data};
    pend_r = bus.mem_acc_read_en && !bus.mem_acc_read_data_valid;
    pr     = bus.mem_acc_read_addr;
    if (bus.mem_acc_write_en && bus.mem_acc_write_done)
      obs_w.push_back({bus.mem_acc_write_addr, bus.mem_acc_write_data});
    if (bus.mem_acc_read_en && bus.mem_acc_read_data_valid) obs_r.push_back(bus.mem_acc_read_addr);
    if (ms_init) obs_sel.push_back(msg_sel);
    if (hash_done) hd_cnt++;
    if (ms_enable) en_cnt++;
    if (!cm_rst_hash_n) rst_cnt++;
    if (save) save_cnt++;
    if (bus64.mem_acc_write_en) obs64.push_back({bus64.mem_acc_write_addr, bus64.mem_acc_write_data});
  endtask

  task automatic clear_obs();
    obs_w.delete(); obs_r.delete(); obs_sel.delete(); obs64.delete();
    hd_cnt = 0; en_cnt = 0; rst_cnt = 0; save_cnt = 0; stab_err = 0;
  endtask

  task automatic push_job(input bit dbl);
    exp_w.delete(); exp_r.delete(); exp_sel.delete();
    exp_w.push_back({16'h5000, 32'h5});
    for (int b = 0; b < 2; b++) begin
      exp_r.push_back(16'h1008 + 16'(b * 'h40));
      exp_sel.push_back(3'(b));
    end
    if (dbl) exp_sel.push_back(3'd2);
    for (int i = 0; i < 8; i++) exp_w.push_back({16'h5008 + 16'(i * 4), cm[32*i +: 32]});
    exp_w.push_back({16'h5000, 32'h2});
  endtask

  task automatic cpu_write(input logic [31:0] d);
    bus.mem_listen_en = 1'b1; bus.mem_listen_addr = 16'h5000; bus.mem_listen_data = d;
    tick();
    bus.mem_listen_en = 1'b0; bus.mem_listen_data = '0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (hd_cnt == 0 && !(obs_w.size() > 0 && obs_w[obs_w.size()-1][31:0] == 32'h12) && n < 3000) begin
      tick(); n++;
    end
    chk({tag, "_timeout"}, 96'(n < 3000), 96'(1));
    repeat (4) tick();
  endtask

  task automatic compare_job(input string tag, input int exp_hd);
    chk({tag, "_wr_count"}, 96'(obs_w.size()), 96'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) chk({tag, "_wr"}, 96'(obs_w[i]), 96'(exp_w[i]));
    chk({tag, "_rd_count"}, 96'(obs_r.size()), 96'(exp_r.size()));
    for (int i = 0; i < exp_r.size() && i < obs_r.size(); i++) chk({tag, "_rd"}, 96'(obs_r[i]), 96'(exp_r[i]));
    chk({tag, "_sel_count"}, 96'(obs_sel.size()), 96'(exp_sel.size()));
    for (int i = 0; i < exp_sel.size() && i < obs_sel.size(); i++) chk({tag, "_sel"}, 96'(obs_sel[i]), 96'(exp_sel[i]));
    chk({tag, "_hash_done"}, 96'(hd_cnt), 96'(exp_hd));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [6:0] c0;
    bus.mem_listen_en = 1'b0; bus.mem_listen_addr = '0; bus.mem_listen_data = '0;
    bus64.mem_listen_en = 1'b0; bus64.mem_listen_addr = '0; bus64.mem_listen_data = '0;
    clear_obs();

    // Reset state
    repeat (3) tick();
    chk("reset_outs", outs(), IDLE_OUTS);
    rst_n = 1'b1;
    tick();
    chk("idle_outs", outs(), IDLE_OUTS);

    // Job A: single hash, zero-latency arbiter; 64-bit instance runs alongside
    cm = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    push_job(1'b0); clear_obs();
    bus64.mem_listen_en = 1'b1; bus64.mem_listen_addr = 16'h5000; bus64.mem_listen_data = 32'h1;
    cpu_write(32'h1);
    bus64.mem_listen_en = 1'b0; bus64.mem_listen_data = '0;
    wait_end("jobA");
    compare_job("jobA", 1);
    chk("jobA_ms_enable_cycles", 96'(en_cnt), 96'(128));
    chk("jobA_rst_hash_cycles", 96'(rst_cnt), 96'(1));
    chk("jobA_save_cycles", 96'(save_cnt), 96'(2));
    chk("w64_count", 96'(obs64.size()), 96'(6));
    if (obs64.size() == 6) begin
      chk("w64_busy", 96'(obs64[0]), 96'({16'h5000, 64'h5}));
      for (int i = 0; i < 4; i++) chk("w64_digest", 96'(obs64[i+1]), 96'({16'h5008 + 16'(i * 4), cm[64*i +: 64]}));
      chk("w64_done", 96'(obs64[5]), 96'({16'h5000, 64'h2}));
    end

    // Job B: double hash
    cm = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    push_job(1'b1); clear_obs();
    cpu_write(32'h21);
    wait_end("jobB");
    compare_job("jobB", 1);
    chk("jobB_ms_enable_cycles", 96'(en_cnt), 96'(192));
    chk("jobB_rst_hash_cycles", 96'(rst_cnt), 96'(2));
    chk("jobB_save_cycles", 96'(save_cnt), 96'(3));

    // Job C: slow arbiter, requests must hold until granted
    arb_max = 5;
    cm = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    push_job(1'b0); clear_obs();
    repeat (2) tick();
    cpu_write(32'h1);
    wait_end("jobC");
    compare_job("jobC", 1);
    chk("jobC_request_stability", 96'(stab_err), 96'(0));
    arb_max = 0;
    repeat (8) tick();

    // Job D: second start and a spurious grant during HASH are ignored
    cm = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    push_job(1'b0); clear_obs();
    cpu_write(32'h1);
    n = 0;
    while (!(ms_enable && cyc == 7'd10) && n < 500) begin tick(); n++; end
    chk("jobD_reach_round10", 96'(n < 500), 96'(1));
    c0 = cyc;
    cpu_write(32'h1);
    chk("jobD_restart_ignored", 96'({ms_enable, cyc}), 96'({1'b1, c0 + 7'd1}));
    spur = 1'b1; tick(); spur = 1'b0;
    wait_end("jobD");
    compare_job("jobD", 1);

    // Job E: abort request in round 30 of the first block
    cm = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
`ifdef ACC_ABORT_EN
    exp_w.delete(); exp_r.delete(); exp_sel.delete();
    exp_w.push_back({16'h5000, 32'h5}); exp_w.push_back({16'h5000, 32'h12});
    exp_r.push_back(16'h1008); exp_sel.push_back(3'd0);
`else
    push_job(1'b0);
`endif
    clear_obs();
    cpu_write(32'h1);
    n = 0;
    while (!(ms_enable && cyc == 7'd30) && n < 500) begin tick(); n++; end
    chk("jobE_reach_round30", 96'(n < 500), 96'(1));
    cpu_write(32'h8);
`ifdef ACC_ABORT_EN
    chk("jobE_abort_write", 96'({bus.mem_acc_write_en, bus.mem_acc_write_addr, bus.mem_acc_write_data}),
        96'({1'b1, 16'h5000, 32'h12}));
    wait_end("jobE");
    compare_job("jobE", 0);
`else
    chk("jobE_abort_ignored", 96'({ms_enable, cyc}), 96'({1'b1, 7'd31}));
    wait_end("jobE");
    compare_job("jobE", 1);
`endif

    // Reset during digest write-back
    clear_obs();
    cpu_write(32'h1);
    n = 0;
    while (!(bus.mem_acc_write_en && bus.mem_acc_write_addr == 16'h5010) && n < 500) begin tick(); n++; end
    chk("reach_write_h", 96'(n < 500), 96'(1));
    rst_n = 1'b0;
    tick();
    chk("midjob_reset_outs", outs(), IDLE_OUTS);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_reset_outs", outs(), IDLE_OUTS);
    chk("post_reset_no_done", 96'(hd_cnt), 96'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
